al422_bam_packer: RTL and testbench

Write-side sequencer for the AL422 line FIFO. On each frame request it walks every row and every BAM bit-plane and emits one packet per (row, plane) into the AL422 write port. Each packet is a 5-byte header (row/polarity, OE active count, OE passive count) followed by COLS pixel bytes with end-of-block and end-of-frame flags. Pixel planes are fetched from a pixel memory. It sits between the frame-buffer/host side and the AL422 write pins, mirroring the packet format consumed by the read-side HUB75E driver.

---
 rtl/al422_bam_packer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_al422_bam_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/al422_bam_packer.sv
// al422_bam_packer: write-side sequencer for the AL422 line FIFO.
// For every (row, plane) pair it writes a 5-byte header and COLS pixel bytes.
// Pixel addresses run two launches ahead of the byte being written, because
// the pixel memory answers one cycle after the address. A one-entry skid
// register keeps the due pixel across wr_hold stalls.
module al422_bam_packer #(
    parameter int ROWS   = 16,
    parameter int COLS   = 64,
    parameter int PLANES = 8,
    parameter int AW     = $clog2(ROWS * COLS)
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  frame_start,
    input  logic [2:0]            cfg_phases,
    input  logic [15:0]           cfg_oe_base,
    input  logic [15:0]           cfg_oe_passive,
    output logic [AW-1:0]         pix_addr,
    input  logic [6*PLANES-1:0]   pix_data,
    output logic [7:0]            al422_wr_data,
    output logic                  al422_we,
    output logic                  al422_wrst_n,
    input  logic                  wr_hold,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [4:0]    ROW_LAST   = 5'(ROWS - 1);
    localparam logic [3:0]    PLANE_LAST = 4'(PLANES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WRST = 3'd1,
        HDR  = 3'd2,
        PIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // OE active time for a plane: base doubled per plane, clamped to 16 bits.
    function automatic logic [15:0] oe_shift(input logic [15:0] base, input logic [3:0] sh);
        logic [31:0] w;
        w = {16'h0000, base} << sh;
        if (w[31:16] != 16'h0000) begin
            return 16'hFFFF;
        end else begin
            return w[15:0];
        end
    endfunction

    // Linear pixel memory address row*COLS + col.
    function automatic logic [AW-1:0] pix_index(input logic [4:0] r, input logic [31:0] c);
        logic [31:0] t;
        t = 32'(r) * 32'(COLS) + c;
        return t[AW-1:0];
    endfunction

    state_t        state_q, state_d;
    logic [4:0]    row_q, row_d;
    logic [3:0]    plane_q, plane_d;
    logic [CW-1:0] col_q, col_d;
    logic [2:0]    hdr_q, hdr_d;
    logic [2:0]    ph_q, ph_d;
    logic [15:0]   base_q, base_d;
    logic [15:0]   pas_q, pas_d;
    logic [5:0]    skid_q, skid_d;
    logic          skid_v_q, skid_v_d;
    logic          we_q, we_d;
    logic          wrst_n_q, wrst_n_d;
    logic [7:0]    data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [5:0]    slice_s;
    logic [5:0]    pix_byte_s;
    logic [15:0]   oe_act_s;
    logic          eob_s;
    logic          last_pkt_s;
    logic          eof_s;
    logic [7:0]    hdr_byte_s;

    assign slice_s    = pix_data[int'(plane_q) * 6 +: 6];
    assign pix_byte_s = skid_v_q ? skid_q : slice_s;
    assign oe_act_s   = oe_shift(base_q, plane_q);
    assign eob_s      = (col_q == COL_LAST);
    assign last_pkt_s = (row_q == ROW_LAST) && (plane_q == PLANE_LAST);
    assign eof_s      = eob_s && last_pkt_s;

    // Header byte selected by the header index of the current packet.
    always_comb begin
        hdr_byte_s = 8'h00;
        case (hdr_q)
            3'd0:    hdr_byte_s = {ph_q, row_q};
            3'd1:    hdr_byte_s = oe_act_s[7:0];
            3'd2:    hdr_byte_s = oe_act_s[15:8];
            3'd3:    hdr_byte_s = pas_q[7:0];
            3'd4:    hdr_byte_s = pas_q[15:8];
            default: hdr_byte_s = 8'h00;
        endcase
    end

    // Next-state logic: counters describe the next byte to be launched.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        plane_d  = plane_q;
        col_d    = col_q;
        hdr_d    = hdr_q;
        ph_d     = ph_q;
        base_d   = base_q;
        pas_d    = pas_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        we_d     = 1'b0;
        wrst_n_d = 1'b1;
        data_d   = data_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    ph_d     = cfg_phases;
                    base_d   = cfg_oe_base;
                    pas_d    = cfg_oe_passive;
                    row_d    = 5'd0;
                    plane_d  = 4'd0;
                    col_d    = '0;
                    hdr_d    = 3'd0;
                    skid_v_d = 1'b0;
                    wrst_n_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = WRST;
                end else begin
                    state_d = IDLE;
                end
            end
            WRST, HDR: begin
                state_d = HDR;
                if (!wr_hold) begin
                    we_d   = 1'b1;
                    data_d = hdr_byte_s;
                    if (hdr_q == 3'd3) begin
                        addr_d = pix_index(row_q, 32'd0);
                    end else if (hdr_q == 3'd4) begin
                        addr_d = pix_index(row_q, 32'd1);
                    end else begin
                        addr_d = addr_q;
                    end
                    if (hdr_q == 3'd4) begin
                        hdr_d   = 3'd0;
                        state_d = PIX;
                    end else begin
                        hdr_d = hdr_q + 3'd1;
                    end
                end else begin
                    we_d = 1'b0;
                end
            end
            PIX: begin
                if (wr_hold) begin
                    // Pixel data for the due byte is only on the bus this cycle.
                    if (!skid_v_q) begin
                        skid_d   = slice_s;
                        skid_v_d = 1'b1;
                    end else begin
                        skid_d = skid_q;
                    end
                end else begin
                    we_d     = 1'b1;
                    data_d   = {eof_s, eob_s, pix_byte_s};
                    skid_v_d = 1'b0;
                    if ((32'(col_q) + 32'd2) < 32'(COLS)) begin
                        addr_d = pix_index(row_q, 32'(col_q) + 32'd2);
                    end else begin
                        addr_d = addr_q;
                    end
                    if (eob_s) begin
                        col_d = '0;
                        if (last_pkt_s) begin
                            state_d = DONE;
                        end else begin
                            state_d = HDR;
                            if (plane_q == PLANE_LAST) begin
                                plane_d = 4'd0;
                                row_d   = row_q + 5'd1;
                            end else begin
                                plane_d = plane_q + 4'd1;
                            end
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DONE: begin
                // First DONE cycle follows the last write; second raises done.
                if (!done_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters, shadow config and registered outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q  <= IDLE;
            row_q    <= 5'd0;
            plane_q  <= 4'd0;
            col_q    <= '0;
            hdr_q    <= 3'd0;
            ph_q     <= 3'd0;
            base_q   <= 16'h0000;
            pas_q    <= 16'h0000;
            skid_q   <= 6'd0;
            skid_v_q <= 1'b0;
            we_q     <= 1'b0;
            wrst_n_q <= 1'b1;
            data_q   <= 8'h00;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            plane_q  <= plane_d;
            col_q    <= col_d;
            hdr_q    <= hdr_d;
            ph_q     <= ph_d;
            base_q   <= base_d;
            pas_q    <= pas_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            we_q     <= we_d;
            wrst_n_q <= wrst_n_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign pix_addr      = addr_q;
    assign al422_wr_data = data_q;
    assign al422_we      = we_q;
    assign al422_wrst_n  = wrst_n_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_al422_bam_packer.sv
// Directed bench for al422_bam_packer with ROWS=2, COLS=4, PLANES=4.
module tb_al422_bam_packer;

    localparam int R    = 2;
    localparam int C    = 4;
    localparam int P    = 4;
    localparam int AW   = 3;
    localparam int FLEN = R * P * (5 + C);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          wr_hold = 1'b0;
    logic [2:0]    cfg_phases = 3'b001;
    logic [15:0]   cfg_oe_base = 16'h0010;
    logic [15:0]   cfg_oe_passive = 16'h0100;
    logic [AW-1:0] pix_addr;
    logic [6*P-1:0] pix_data = '0;
    logic [7:0]    wr_data;
    logic          we;
    logic          wrst_n;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [7:0] cap[$];
    logic [7:0] expq[$];
    int cyc = 0;
    int first_we = -1;
    int last_we = -1;
    int wrst_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int viol = 0;
    bit seen;

    al422_bam_packer #(.ROWS(R), .COLS(C), .PLANES(P), .AW(AW)) dut (
        .in_clk(clk), .in_rst(rst), .frame_start(frame_start),
        .cfg_phases(cfg_phases), .cfg_oe_base(cfg_oe_base), .cfg_oe_passive(cfg_oe_passive),
        .pix_addr(pix_addr), .pix_data(pix_data), .al422_wr_data(wr_data),
        .al422_we(we), .al422_wrst_n(wrst_n), .wr_hold(wr_hold),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Pixel memory content: each plane slice is a distinct function of the address.
    function automatic logic [6*P-1:0] pix_word(input int a);
        logic [6*P-1:0] w;
        for (int p = 0; p < P; p++) w[6*p +: 6] = 6'((a * 5 + p * 17 + 3) % 64);
        return w;
    endfunction

    // Pixel memory: one-cycle read latency.
    always @(posedge clk) pix_data <= pix_word(int'(pix_addr));

    // Write-port monitor sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (we) begin
            cap.push_back(wr_data);
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (wr_hold) viol = viol + 1;
        end
        if (!wrst_n) wrst_cnt = wrst_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        cap.delete();
        first_we = -1; last_we = -1; wrst_cnt = 0; done_cnt = 0; done_cyc = -1; viol = 0;
    endtask

    // Reference frame built as nested row/plane/column loops.
    task automatic build_exp(input logic [2:0] ph, input logic [15:0] base, input logic [15:0] pas);
        longint oe;
        logic [15:0] oes;
        logic [6*P-1:0] w;
        logic eob, eof;
        expq.delete();
        for (int r = 0; r < R; r++) begin
            for (int p = 0; p < P; p++) begin
                oe  = longint'(base) << p;
                oes = (oe > 64'd65535) ? 16'hFFFF : 16'(oe);
                expq.push_back({ph, 5'(r)});
                expq.push_back(oes[7:0]);
                expq.push_back(oes[15:8]);
                expq.push_back(pas[7:0]);
                expq.push_back(pas[15:8]);
                for (int c = 0; c < C; c++) begin
                    w   = pix_word(r * C + c);
                    eob = (c == C - 1);
                    eof = eob && (r == R - 1) && (p == P - 1);
                    expq.push_back({eof, eob, w[6*p +: 6]});
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_wrst_n"}, 32'(wrst_n), 32'd1);
        chk({tag, "_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_addr"}, 32'(pix_addr), 32'd0);
    endtask

    // Pulse frame_start and check the WRST cycle and the first header byte.
    task automatic start_frame(input string tag, input logic [7:0] b0);
        @(negedge clk); frame_start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_wrst_low"}, 32'(wrst_n), 32'd0);
        chk({tag, "_busy_up"}, 32'(busy), 32'd1);
        chk({tag, "_we_in_wrst"}, 32'(we), 32'd0);
        @(negedge clk); frame_start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_b0_we"}, 32'(we), 32'd1);
        chk({tag, "_b0"}, 32'(wr_data), 32'(b0));
    endtask

    task automatic pulse_frame();
        @(negedge clk); frame_start = 1'b1;
    endtask

    // Run until done with a cycle budget; optional random hold and extra frame_start pulses.
    task automatic wait_done(input string tag, input bit rnd, input bit dup);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            wr_hold = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            frame_start = dup && (i == 4 || i == 9);
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk); wr_hold = 1'b0; frame_start = dup;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 32'(cap.size()), 32'(FLEN));
        for (int i = 0; i < FLEN; i++) begin
            chk($sformatf("%s_b%0d", tag, i), (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD, 32'(expq[i]));
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;

        // Unstalled frame, base 0x0010, passive 0x0100, phases 001
        build_exp(3'b001, 16'h0010, 16'h0100);
        clear_mon();
        start_frame("f1", 8'h20);
        wait_done("f1", 1'b0, 1'b0);
        cmp_stream("f1");
        chk("f1_r1p1_b0", 32'(cap[45]), 32'h21);
        chk("f1_r1p1_b1", 32'(cap[46]), 32'h20);
        chk("f1_r1p1_b2", 32'(cap[47]), 32'h00);
        chk("f1_r1p1_b3", 32'(cap[48]), 32'h00);
        chk("f1_r1p1_b4", 32'(cap[49]), 32'h01);
        chk("f1_pix_r0p0c0", 32'(cap[5]), 32'h03);
        chk("f1_pix_r0p0c3_eob", 32'(cap[8]), 32'h52);
        chk("f1_last_eof", 32'(cap[71]), 32'hD9);
        chk("f1_no_eob_c2", 32'(cap[43][6]), 32'd0);
        chk("f1_no_eof_p6", 32'(cap[62][7]), 32'd0);
        chk("f1_first_we", 32'(first_we + 1), 32'(first_we + 1 > 0 ? first_we + 1 : 0));
        chk("f1_contiguous", 32'(last_we - first_we + 1), 32'(FLEN));
        chk("f1_done_after_last", 32'(done_cyc), 32'(last_we + 1));
        chk("f1_wrst_pulses", 32'(wrst_cnt), 32'd1);
        chk("f1_done_pulses", 32'(done_cnt), 32'd1);

        // Saturating OE shift
        cfg_oe_base = 16'h4000;
        build_exp(3'b001, 16'h4000, 16'h0100);
        clear_mon();
        pulse_frame();
        wait_done("sat", 1'b0, 1'b0);
        cmp_stream("sat");
        chk("sat_p0_lo", 32'(cap[1]), 32'h00);
        chk("sat_p0_hi", 32'(cap[2]), 32'h40);
        chk("sat_p1_lo", 32'(cap[10]), 32'h00);
        chk("sat_p1_hi", 32'(cap[11]), 32'h80);
        chk("sat_p2_lo", 32'(cap[19]), 32'hFF);
        chk("sat_p2_hi", 32'(cap[20]), 32'hFF);
        chk("sat_p3_lo", 32'(cap[28]), 32'hFF);
        chk("sat_p3_hi", 32'(cap[29]), 32'hFF);

        // Random wr_hold over a whole frame
        cfg_oe_base = 16'h0010;
        build_exp(3'b001, 16'h0010, 16'h0100);
        clear_mon();
        pulse_frame();
        wait_done("hold", 1'b1, 1'b0);
        cmp_stream("hold");
        chk("hold_no_write_in_hold", 32'(viol), 32'd0);

        // Extra frame_start pulses mid-frame and in the done cycle
        clear_mon();
        pulse_frame();
        wait_done("dup", 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        chk("dup_wrst_pulses", 32'(wrst_cnt), 32'd1);
        chk("dup_done_pulses", 32'(done_cnt), 32'd1);
        chk("dup_busy_idle", 32'(busy), 32'd0);
        chk("dup_len", 32'(cap.size()), 32'(FLEN));

        // Asynchronous reset in the middle of the pixel stream
        pulse_frame();
        @(negedge clk); frame_start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("midrst_in_pix_we", 32'(we), 32'd1);
        chk("midrst_in_pix_flags", 32'(wr_data[7:6]), 32'd0);
        #2; rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk); rst = 1'b0;
        clear_mon();
        start_frame("rst2", 8'h20);
        wait_done("rst2", 1'b0, 1'b0);
        cmp_stream("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
